// File: rtl/core_control_fsm.sv
// Multi-cycle control sequencer for the RV32I core: fetch handshake, execute/memory/
// write-back stepping, timed PAUSE stall, bus timeout trap and retired-instruction count.
module core_control_fsm #(
   parameter int unsigned PAUSE_CYCLES = 16,
   parameter int unsigned MEM_TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        dec_data_r,
   input  logic        dec_data_w,
   input  logic        dec_reg_w,
   input  logic        dec_branch,
   input  logic        dec_jump,
   input  logic        dec_pause,
   input  logic        branch_taken,
   output logic        imem_req,
   output logic        ir_load,
   output logic        alu_en,
   output logic        dmem_re,
   output logic        dmem_we,
   output logic        rf_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic [2:0]  state,
   output logic        bus_error,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_PAUSE   = 3'd5,
      ST_ERROR   = 3'd7
   } state_t;

   localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
   localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [7:0]  pause_q, pause_d;
   logic        taken_q, taken_d;
   logic [31:0] instret_q, instret_d;
   logic        mem_access;

   assign mem_access = dec_data_r | dec_data_w;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      pause_d   = pause_q;
      taken_d   = taken_q;
      instret_d = instret_q;

      case (state_q)
         ST_FETCH: begin
            if (!run) begin
               wait_d = '0;
            end else if (imem_ack) begin
               state_d = ST_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_ERROR;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            taken_d = dec_branch & branch_taken;
            if (dec_pause) begin
               state_d = ST_PAUSE;
               pause_d = PAUSE_LOAD;
            end else if (mem_access) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            // A MEM visit without any access request has nothing to wait for.
            if (dmem_ack || !mem_access) begin
               state_d = ST_WB;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_ERROR;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_PAUSE: begin
            if (pause_q == 8'd0) begin
               state_d = ST_WB;
            end else begin
               pause_d = pause_q - 8'd1;
            end
         end
         ST_WB: begin
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      if (state_d != state_q) begin
         wait_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         wait_q    <= '0;
         pause_q   <= '0;
         taken_q   <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         pause_q   <= pause_d;
         taken_q   <= taken_d;
         instret_q <= instret_d;
      end
   end

   // Strobes decode straight from the state register so that reset removes them at once.
   always_comb begin
      imem_req = 1'b0;
      ir_load  = 1'b0;
      alu_en   = 1'b0;
      dmem_re  = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;

      case (state_q)
         ST_FETCH: begin
            imem_req = run;
            ir_load  = run & imem_ack;
         end
         ST_EXECUTE: begin
            alu_en = 1'b1;
         end
         ST_MEM: begin
            dmem_re = dec_data_r;
            dmem_we = dec_data_w;
         end
         ST_WB: begin
            pc_we  = 1'b1;
            pc_sel = dec_jump | taken_q;
            rf_we  = dec_reg_w & ~dec_data_w & ~dec_pause;
         end
         default: begin
         end
      endcase

      if (reset) begin
         imem_req = 1'b0;
         ir_load  = 1'b0;
         alu_en   = 1'b0;
         dmem_re  = 1'b0;
         dmem_we  = 1'b0;
         rf_we    = 1'b0;
         pc_we    = 1'b0;
         pc_sel   = 1'b0;
      end
   end

   assign state     = state_q;
   assign bus_error = (state_q == ST_ERROR) & ~reset;
   assign instret   = instret_q;

endmodule

// File: tb/tb_core_control_fsm.sv
// Self-checking bench for core_control_fsm: each instruction is expanded into the
// cycle-by-cycle input/expected-output records it must produce, then replayed and compared.
module tb_core_control_fsm;

   localparam int unsigned PAUSE_CYCLES = 16;
   localparam int unsigned MEM_TIMEOUT  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        run, imem_ack, dmem_ack;
   logic        dec_data_r, dec_data_w, dec_reg_w, dec_branch, dec_jump, dec_pause;
   logic        branch_taken;
   logic        imem_req, ir_load, alu_en, dmem_re, dmem_we, rf_we, pc_we, pc_sel;
   logic [2:0]  state;
   logic        bus_error;
   logic [31:0] instret;

   typedef struct {
      logic        run, imem_ack, dmem_ack, branch_taken;
      logic        d_r, d_w, reg_w, br, jmp, pau;
      logic [2:0]  st;
      logic        imem_req, ir_load, alu_en, dmem_re, dmem_we, rf_we, pc_we, pc_sel, berr;
      logic [31:0] instret;
   } cyc_t;

   cyc_t        stim_q[$];
   cyc_t        exp_q[$];
   logic [31:0] exp_instret = '0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc_n = 0;

   core_control_fsm #(.PAUSE_CYCLES(PAUSE_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .dec_data_r(dec_data_r), .dec_data_w(dec_data_w), .dec_reg_w(dec_reg_w),
      .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_pause(dec_pause),
      .branch_taken(branch_taken), .imem_req(imem_req), .ir_load(ir_load),
      .alu_en(alu_en), .dmem_re(dmem_re), .dmem_we(dmem_we), .rf_we(rf_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .state(state), .bus_error(bus_error),
      .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc_n, act, exp);
      end
   endtask

   task automatic checkOutput(input cyc_t r);
      checkVal("state",     32'(state),     32'(r.st));
      checkVal("imem_req",  32'(imem_req),  32'(r.imem_req));
      checkVal("ir_load",   32'(ir_load),   32'(r.ir_load));
      checkVal("alu_en",    32'(alu_en),    32'(r.alu_en));
      checkVal("dmem_re",   32'(dmem_re),   32'(r.dmem_re));
      checkVal("dmem_we",   32'(dmem_we),   32'(r.dmem_we));
      checkVal("rf_we",     32'(rf_we),     32'(r.rf_we));
      checkVal("pc_we",     32'(pc_we),     32'(r.pc_we));
      checkVal("pc_sel",    32'(pc_sel),    32'(r.pc_sel));
      checkVal("bus_error", 32'(bus_error), 32'(r.berr));
      checkVal("instret",   instret,        r.instret);
   endtask

   task automatic applyStimulus(input cyc_t r);
      run          = r.run;
      imem_ack     = r.imem_ack;
      dmem_ack     = r.dmem_ack;
      branch_taken = r.branch_taken;
      dec_data_r   = r.d_r;
      dec_data_w   = r.d_w;
      dec_reg_w    = r.reg_w;
      dec_branch   = r.br;
      dec_jump     = r.jmp;
      dec_pause    = r.pau;
   endtask

   // Cycles spent in FETCH requesting without an acknowledge.
   task automatic addFetchWait(input int n);
      cyc_t r;
      r = '{default: '0};
      r.run      = 1'b1;
      r.imem_req = 1'b1;
      r.instret  = exp_instret;
      for (int i = 0; i < n; i++) stim_q.push_back(r);
   endtask

   // Cycles with no strobes at all: idle FETCH with run low, or the ERROR trap.
   task automatic addIdle(input int n, input logic rn, input logic ack, input logic [2:0] st,
                          input logic berr);
      cyc_t r;
      r = '{default: '0};
      r.run      = rn;
      r.imem_ack = ack;
      r.dmem_ack = ack;
      r.st       = st;
      r.berr     = berr;
      r.instret  = exp_instret;
      for (int i = 0; i < n; i++) stim_q.push_back(r);
   endtask

   // One instruction from its accepted fetch to write-back; ack_at = 1-based MEM ack cycle, 0 = never.
   task automatic addInstr(input logic d_r, input logic d_w, input logic reg_w, input logic br,
                           input logic jmp, input logic pau, input logic taken, input int ack_at);
      cyc_t r;
      logic done;
      r = '{default: '0};
      r.d_r = d_r; r.d_w = d_w; r.reg_w = reg_w; r.br = br; r.jmp = jmp; r.pau = pau;
      r.instret  = exp_instret;
      r.run      = 1'b1;
      r.imem_ack = 1'b1;
      r.imem_req = 1'b1;
      r.ir_load  = 1'b1;
      r.st       = 3'd0;
      stim_q.push_back(r);
      r.run = 1'b0; r.imem_req = 1'b0; r.ir_load = 1'b0;
      r.st = 3'd1;
      stim_q.push_back(r);
      r.st = 3'd2; r.alu_en = 1'b1; r.branch_taken = taken;
      stim_q.push_back(r);
      r.alu_en = 1'b0; r.branch_taken = 1'b0;
      if (pau) begin
         r.st = 3'd5;
         for (int i = 0; i < int'(PAUSE_CYCLES); i++) stim_q.push_back(r);
      end else if (d_r | d_w) begin
         done = 1'b0;
         r.st = 3'd3; r.dmem_re = d_r; r.dmem_we = d_w;
         for (int k = 1; k <= int'(MEM_TIMEOUT) && !done; k++) begin
            r.dmem_ack = (k == ack_at);
            stim_q.push_back(r);
            if (k == ack_at) done = 1'b1;
         end
         r.dmem_re = 1'b0; r.dmem_we = 1'b0; r.dmem_ack = 1'b0;
         if (!done) return;
      end
      r.st     = 3'd4;
      r.pc_we  = 1'b1;
      r.pc_sel = jmp | (br & taken);
      r.rf_we  = reg_w & ~d_w & ~pau;
      stim_q.push_back(r);
      exp_instret = exp_instret + 32'd1;
   endtask

   task automatic runQueue();
      cyc_t r;
      while (stim_q.size() > 0) begin
         @(posedge clk);
         #1;
         r = stim_q.pop_front();
         applyStimulus(r);
         exp_q.push_back(r);
      end
      @(negedge clk);
      #1;
      run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b1;
      dec_data_r = 1'b1; dec_data_w = 1'b1; dec_reg_w = 1'b1;
      dec_branch = 1'b1; dec_jump = 1'b1; dec_pause = 1'b1;
      #1;
      checkVal("reset_outputs", 32'({imem_req, ir_load, alu_en, dmem_re, dmem_we, rf_we,
                                     pc_we, pc_sel, bus_error, state}), 32'd0);
      checkVal("reset_instret", instret, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checkVal("reset_hold_outputs", 32'({imem_req, ir_load, alu_en, dmem_re, dmem_we, rf_we,
                                          pc_we, pc_sel, bus_error, state}), 32'd0);
      @(negedge clk);
      applyStimulus('{default: '0});
      reset = 1'b0;
      exp_instret = '0;
   endtask

   // Compare process: every replayed record is checked half a cycle after it is applied.
   initial begin
      cyc_t r;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            cyc_n++;
            checkOutput(r);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      doReset();

      // Ten back-to-back ADDIs, zero-wait fetch.
      addInstr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      checkVal("model_len_addi", stim_q.size(), 32'd4);
      for (int i = 0; i < 9; i++) addInstr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      checkVal("model_len_10_addi", stim_q.size(), 32'd40);
      runQueue();
      @(posedge clk);
      #2;
      checkVal("instret_after_10_addi", instret, 32'd10);

      // Load acknowledged in its 4th MEM cycle.
      addInstr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
      checkVal("model_len_load", stim_q.size(), 32'd8);
      runQueue();

      // Store, taken branch, untaken branch, fetch stalls with a run drop, then JAL.
      addInstr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      addInstr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      addInstr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      addFetchWait(2);
      addIdle(1, 1'b0, 1'b0, 3'd0, 1'b0);
      addFetchWait(3);
      addInstr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      runQueue();

      // PAUSE stall.
      addInstr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      checkVal("model_len_pause", stim_q.size(), 32'd20);
      runQueue();
      @(posedge clk);
      #2;
      checkVal("instret_after_pause", instret, 32'd16);

      // Load never acknowledged: trap into ERROR.
      doReset();
      addInstr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      addIdle(6, 1'b1, 1'b1, 3'd7, 1'b1);
      runQueue();
      checkVal("error_state", 32'(state), 32'd7);
      checkVal("error_flag", 32'(bus_error), 32'd1);

      // Same load acknowledged on the last allowed cycle completes normally.
      doReset();
      addInstr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MEM_TIMEOUT);
      runQueue();

      // Store stalled in MEM, interrupted by reset between clock edges.
      addInstr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      while (stim_q.size() > 5) void'(stim_q.pop_back());
      runQueue();
      #2;
      checkVal("dmem_we_before_reset", 32'(dmem_we), 32'd1);
      reset = 1'b1;
      #1;
      checkVal("dmem_we_async_drop", 32'(dmem_we), 32'd0);
      checkVal("state_async_reset", 32'(state), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      applyStimulus('{default: '0});
      reset = 1'b0;
      exp_instret = '0;
      #1;
      checkVal("state_after_release", 32'(state), 32'd0);
      checkVal("instret_after_release", instret, 32'd0);

      // Long idle with run low: no request and no timeout.
      addIdle(300, 1'b0, 1'b0, 3'd0, 1'b0);
      runQueue();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
